key_scanner: RTL and testbench
==============================

KEY_SCANNER -- requirements
Module: key_scanner

Interface
REQ-001 Parameter COLS, default 4: number of matrix columns driven.
REQ-002 Parameter ROWS, default 4: number of matrix rows sampled.
REQ-003 Parameter SETTLE_CYCLES, default 8: cycles a column is driven before its rows are sampled.
REQ-004 Parameter DEBOUNCE_SCANS, default 4: consecutive differing samples required to change a key's state.
REQ-005 Parameter FIFO_DEPTH, default 4: event queue depth.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  1 = scanning runs.
REQ-009 col_n  out  COLS  column drive, active-low; at most one bit low.
REQ-010 row_n  in  ROWS  row sense, asynchronous, active-low (0 = pressed).
REQ-011 key_state  out  COLS*ROWS  debounced state; bit index = col*ROWS+row; 1 = pressed.
REQ-012 event_valid  out  1  FIFO head valid.
REQ-013 event_ready  in  1  consumer accepts head.
REQ-014 event_code  out  log2(COLS*ROWS)  key index of head event.
REQ-015 event_press  out  1  1 = press, 0 = release.
REQ-016 overflow  out  1  sticky: an event was dropped.
REQ-017 clear_overflow  in  1  clears overflow.

Function
REQ-018 The block SHALL pass row_n through a 2-flop synchronizer (reset value all 1) before use.
REQ-019 The FSM SHALL have the states IDLE, DRIVE, SAMPLE and UPDATE.
- IDLE: col_n all 1; enable=1 -> DRIVE with column 0.
- DRIVE: col_n[c]=0 for exactly SETTLE_CYCLES cycles -> SAMPLE.
- SAMPLE: 1 cycle; latch the inverted synchronized rows -> UPDATE.
- UPDATE: ROWS cycles, one row per cycle in ascending order; afterwards enable=0 -> IDLE, otherwise DRIVE with c+1, wrapping COLS-1 -> 0.
REQ-020 With defaults, one column SHALL take 13 cycles and one full scan 52 cycles.
REQ-021 Each key SHALL carry a debounce counter of width clog2(DEBOUNCE_SCANS); in UPDATE, when sample equals key_state the counter clears to 0.
REQ-022 When sample differs and counter = DEBOUNCE_SCANS-1, the key SHALL toggle key_state, clear its counter and push {code, new state}; otherwise the counter increments.
REQ-023 A change SHALL therefore need DEBOUNCE_SCANS consecutive differing scans, and any agreeing scan SHALL restart the count.
REQ-024 Deasserting enable SHALL take effect only at the end of UPDATE; key_state and the counters are retained; re-enable restarts at column 0.
REQ-025 The FIFO SHALL be first-in first-out: event_valid = not empty; a pop occurs when event_valid & event_ready; head data holds stable while valid & !ready.
REQ-026 A push when full without a same-cycle pop SHALL drop the event, set overflow, and still update key_state.
REQ-027 A push when full with a same-cycle pop SHALL be accepted and leave the count at FIFO_DEPTH.
REQ-028 A push and pop on an empty FIFO SHALL not bypass: the event becomes valid the next cycle.
REQ-029 clear_overflow SHALL clear overflow next cycle; a simultaneous drop SHALL win, leaving overflow=1.

Reset
REQ-030 While reset_n=0, the block SHALL hold col_n all 1, key_state 0, event_valid 0, overflow 0, FIFO empty, all counters 0, FSM in IDLE and column index 0, all asynchronously and regardless of clk.
REQ-031 After reset_n rises, scanning SHALL begin on the first clk edge with enable=1.

Verification
REQ-032 Hold key 5 (col 1, row 1) pressed -> after 4 scans of column 1, exactly one event {code 5, press 1} is issued, key_state[5]=1, and no further events follow while held.
REQ-033 Press key 5 for 3 scans, then release -> no event is issued and key_state stays 0.
REQ-034 With event_ready=0, press keys 0 to 4 together -> events 0,1,2,3 are queued, key 4's event is dropped, overflow=1, and key_state[4:0]=5'h1F; then with event_ready=1 -> codes 0,1,2,3 appear in order.
REQ-035 With the FIFO full, a push and a pop in the same cycle -> count stays 4, no overflow, and the new event appears 4th.
REQ-036 Drive reset_n=0 in mid-UPDATE -> col_n=4'hF, event_valid=0 and key_state=0 within the same cycle, before the next clk edge.
REQ-037 Drop enable during DRIVE -> the current column completes, col_n=4'hF no later than 13 cycles afterwards, and key_state is unchanged.

Source files
------------

// File: rtl/key_scanner_if.sv
// key_scanner_if -- key event stream between the matrix scanner and its consumer.
//
// Signals:
//   event_valid  producer -> consumer  head of the event queue is valid
//   event_ready  consumer -> producer  consumer accepts the head this cycle
//   event_code   producer -> consumer  key index (col*ROWS+row) of the head event
//   event_press  producer -> consumer  1 = press, 0 = release
//
// Modports:
//   master  the scanner (drives the event fields)
//   slave   the consumer (drives event_ready)
interface key_scanner_if #(
  parameter int CODE_W = 4
);
  logic              event_valid;
  logic              event_ready;
  logic [CODE_W-1:0] event_code;
  logic              event_press;

  modport master (
    output event_valid,
    output event_code,
    output event_press,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_code,
    input  event_press,
    output event_ready
  );
endinterface

// File: rtl/key_scanner.sv
// key_scanner -- debounced COLS x ROWS key-matrix scanner with an event queue.
//
// One column at a time is driven low, left to settle for SETTLE_CYCLES
// cycles, then the synchronized rows are latched and the keys of that column
// are debounced one per cycle. A key changes state only after DEBOUNCE_SCANS
// consecutive scans that disagree with its current state; each change is
// queued as {code, press} in a FIFO_DEPTH-entry FIFO.
//
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   enable          1 = scanning runs; 0 stops at the end of the current column
//   col_n           column drive, active-low, at most one bit low (registered)
//   row_n           row sense, asynchronous, active-low (0 = pressed)
//   key_state       debounced key state, bit col*ROWS+row, 1 = pressed
//   evt             event stream (master side): valid/ready/code/press
//   overflow        sticky, set when an event is dropped on a full queue
//   clear_overflow  clears overflow next cycle (a same-cycle drop wins)
module key_scanner #(
  parameter int COLS           = 4,
  parameter int ROWS           = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  output logic [COLS-1:0]      col_n,
  input  logic [ROWS-1:0]      row_n,
  output logic [COLS*ROWS-1:0] key_state,
  key_scanner_if.master        evt,
  output logic                 overflow,
  input  logic                 clear_overflow
);

  // ------------------------------------------------------------------------
  // Derived widths and terminal values
  // ------------------------------------------------------------------------
  localparam int KEYS   = COLS * ROWS;
  localparam int CODE_W = (KEYS > 1)           ? $clog2(KEYS)           : 1;
  localparam int COL_W  = (COLS > 1)           ? $clog2(COLS)           : 1;
  localparam int ROW_W  = (ROWS > 1)           ? $clog2(ROWS)           : 1;
  localparam int SET_W  = (SETTLE_CYCLES > 1)  ? $clog2(SETTLE_CYCLES)  : 1;
  localparam int CNT_W  = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1)     ? $clog2(FIFO_DEPTH)     : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(ROWS - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DEB_LAST    = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL   = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    UPDATE
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              press;
  } event_t;

  // ------------------------------------------------------------------------
  // Row synchronizer: row_n is asynchronous to clk. Idle value is all-ones
  // (no key pressed), so reset to that rather than to zero.
  // ------------------------------------------------------------------------
  logic [ROWS-1:0] row_meta;
  logic [ROWS-1:0] row_sync;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  // ------------------------------------------------------------------------
  // Scan FSM
  // ------------------------------------------------------------------------
  state_t           state_q,  state_d;
  logic [COL_W-1:0] col_q,    col_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [ROW_W-1:0] row_q,    row_d;
  logic [COLS-1:0]  col_n_q,  col_n_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      col_q    <= '0;
      settle_q <= '0;
      row_q    <= '0;
      col_n_q  <= '1;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      settle_q <= settle_d;
      row_q    <= row_d;
      col_n_q  <= col_n_d;
    end
  end

  // NOTE: every variable written here gets its default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    settle_d = settle_q;
    row_d    = row_q;
    col_n_d  = '1;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = DRIVE;
          col_d    = '0;
          settle_d = '0;
        end
      end

      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      SAMPLE: begin
        state_d = UPDATE;
        row_d   = '0;
      end

      UPDATE: begin
        if (row_q == ROW_LAST) begin
          // enable is only looked at here, so a started column always finishes.
          if (!enable) begin
            state_d = IDLE;
          end else begin
            state_d  = DRIVE;
            settle_d = '0;
            col_d    = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The column stays driven through SAMPLE and UPDATE; col_n is registered
    // from the next state so the pad never glitches.
    if (state_d != IDLE) begin
      col_n_d[col_d] = 1'b0;
    end
  end

  assign col_n = col_n_q;

  // ------------------------------------------------------------------------
  // Row sample latched once per column (rows are active-low, store 1 = pressed)
  // ------------------------------------------------------------------------
  logic [ROWS-1:0] sample_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= '0;
    end else if (state_q == SAMPLE) begin
      sample_q <= ~row_sync;
    end
  end

  // ------------------------------------------------------------------------
  // Per-key debounce, one key per UPDATE cycle
  // ------------------------------------------------------------------------
  logic [CNT_W-1:0]  deb_cnt [KEYS];
  logic [KEYS-1:0]   key_state_q;
  logic [CODE_W-1:0] key_idx;
  logic              cur_sample;
  logic              cur_state;
  logic              differ;
  logic              at_limit;
  logic              in_update;
  logic              push;
  event_t            push_data;

  assign key_idx    = CODE_W'(int'(col_q) * ROWS + int'(row_q));
  assign cur_sample = sample_q[row_q];
  assign cur_state  = key_state_q[key_idx];
  assign differ     = (cur_sample != cur_state);
  assign at_limit   = (deb_cnt[key_idx] == DEB_LAST);
  assign in_update  = (state_q == UPDATE);
  assign push       = in_update && differ && at_limit;
  assign push_data  = '{code: key_idx, press: ~cur_state};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_state_q <= '0;
      for (int i = 0; i < KEYS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else if (in_update) begin
      if (!differ) begin
        deb_cnt[key_idx] <= '0;
      end else if (at_limit) begin
        // key_state changes even if the FIFO has to drop the event.
        key_state_q[key_idx] <= ~cur_state;
        deb_cnt[key_idx]     <= '0;
      end else begin
        deb_cnt[key_idx] <= deb_cnt[key_idx] + 1'b1;
      end
    end
  end

  assign key_state = key_state_q;

  // ------------------------------------------------------------------------
  // Event FIFO
  // ------------------------------------------------------------------------
  event_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              fifo_full;
  logic              fifo_valid;
  logic              pop;
  logic              accept;
  logic              drop;
  logic              overflow_q;
  event_t            head;

  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign fifo_valid = (fifo_cnt != '0);
  assign pop        = fifo_valid && evt.event_ready;
  // A pop on a full queue frees the slot the same cycle. An empty queue never
  // pops, so a pushed event only shows up the following cycle.
  assign accept     = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  // NOTE: the storage array has no reset; emptiness is carried by fifo_cnt,
  // and stale entries are never presented because event_valid gates them.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  assign head            = fifo_mem[rd_ptr];
  assign evt.event_valid = fifo_valid;
  assign evt.event_code  = head.code;
  assign evt.event_press = head.press;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_key_scanner.sv
// tb_key_scanner -- directed self-checking bench for key_scanner (default
// parameters). A behavioral key matrix pulls a row low whenever its column is
// driven and the key in the 'pressed' vector is held. Cycle numbers in the
// comments count rising edges after enable is raised: E0 starts column 0.
// Key (c, r) is debounced on edge 13*c + 10 + r + 52*scan.
module tb_key_scanner;
  localparam int COLS   = 4;
  localparam int ROWS   = 4;
  localparam int KEYS   = COLS * ROWS;
  localparam int CODE_W = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic            clear_overflow;
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic [KEYS-1:0] key_state;
  logic            overflow;
  logic [KEYS-1:0] pressed;

  int n_checks     = 0;
  int n_errors     = 0;
  int valid_cycles = 0;
  int vc_start;

  key_scanner_if #(.CODE_W(CODE_W)) evt ();

  key_scanner #(
    .COLS          (COLS),
    .ROWS          (ROWS),
    .SETTLE_CYCLES (8),
    .DEBOUNCE_SCANS(4),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .col_n         (col_n),
    .row_n         (row_n),
    .key_state     (key_state),
    .evt           (evt),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  // Key matrix model.
  always_comb begin
    row_n = '1;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!col_n[c] && pressed[c*ROWS+r]) row_n[r] = 1'b0;
      end
    end
  end

  // Number of cycles the queue head was valid, used to prove no events appear.
  always @(posedge clk) begin
    if (reset_n && evt.event_valid) valid_cycles <= valid_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset, then leave the bench 1 time unit after an edge with enable low.
  task automatic do_reset();
    reset_n           = 1'b0;
    enable            = 1'b0;
    clear_overflow    = 1'b0;
    evt.event_ready   = 1'b0;
    pressed           = '0;
    tick(3);
    reset_n = 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    reset_n         = 1'b0;
    enable          = 1'b1;
    clear_overflow  = 1'b0;
    evt.event_ready = 1'b0;
    pressed         = '0;
    tick(3);
    check("rst_col_n",     32'(col_n),           32'hF);
    check("rst_key_state", 32'(key_state),       32'h0);
    check("rst_valid",     32'(evt.event_valid), 32'h0);
    check("rst_overflow",  32'(overflow),        32'h0);

    // ---------------- scan timing: 13 cycles/column, 52/scan ----------------
    do_reset();
    enable = 1'b1;
    tick(1);  check("t_e0_col0",   32'(col_n), 32'hE);
    tick(12); check("t_e12_col0",  32'(col_n), 32'hE);
    tick(1);  check("t_e13_col1",  32'(col_n), 32'hD);
    tick(13); check("t_e26_col2",  32'(col_n), 32'hB);
    tick(13); check("t_e39_col3",  32'(col_n), 32'h7);
    tick(13); check("t_e52_wrap",  32'(col_n), 32'hE);

    // ---------------- key 5 held: one press event after 4 scans ----------------
    do_reset();
    pressed[5] = 1'b1;
    enable     = 1'b1;
    tick(180);   // E179
    check("k5_pre_state", 32'(key_state),       32'h0);
    check("k5_pre_valid", 32'(evt.event_valid), 32'h0);
    tick(1);     // E180
    check("k5_state", 32'(key_state),       32'h20);
    check("k5_valid", 32'(evt.event_valid), 32'h1);
    check("k5_code",  32'(evt.event_code),  32'h5);
    check("k5_press", 32'(evt.event_press), 32'h1);
    evt.event_ready = 1'b1;
    tick(1);     // E181: popped
    check("k5_popped", 32'(evt.event_valid), 32'h0);
    vc_start = valid_cycles;
    tick(156);
    check("k5_no_more_events", 32'(valid_cycles - vc_start), 32'h0);
    check("k5_still_pressed",  32'(key_state),               32'h20);

    // ---------------- key 5 bounce: 3 scans then release ----------------
    do_reset();
    pressed[5] = 1'b1;
    enable     = 1'b1;
    vc_start   = valid_cycles;
    tick(141);   // E140: three differing scans counted, fourth not yet sampled
    pressed[5] = 1'b0;
    tick(160);
    check("bounce_events", 32'(valid_cycles - vc_start), 32'h0);
    check("bounce_state",  32'(key_state),               32'h0);

    // ---------------- overflow: keys 0..4 with consumer stalled ----------------
    do_reset();
    pressed[4:0] = 5'h1F;
    enable       = 1'b1;
    tick(179);   // E178: keys 0..3 queued, key 4 not yet
    check("ovf_pre_flag",  32'(overflow),        32'h0);
    check("ovf_pre_state", 32'(key_state),       32'h000F);
    check("ovf_pre_valid", 32'(evt.event_valid), 32'h1);
    clear_overflow = 1'b1;   // same cycle as the drop: drop must win
    tick(1);     // E179: key 4 pushed into full queue
    clear_overflow = 1'b0;
    check("ovf_flag_drop_wins", 32'(overflow),  32'h1);
    check("ovf_state",          32'(key_state), 32'h001F);
    evt.event_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_valid%0d", i), 32'(evt.event_valid), 32'h1);
      check($sformatf("ovf_code%0d", i),  32'(evt.event_code),  32'(i));
      check($sformatf("ovf_press%0d", i), 32'(evt.event_press), 32'h1);
      tick(1);
    end
    check("ovf_drained", 32'(evt.event_valid), 32'h0);
    check("ovf_sticky",  32'(overflow),        32'h1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'h0);

    // ---------------- full queue with push and pop in the same cycle ----------------
    do_reset();
    pressed[4:0] = 5'h1F;
    enable       = 1'b1;
    tick(179);   // E178: full with 0..3
    check("fp_head0", 32'(evt.event_code), 32'h0);
    evt.event_ready = 1'b1;
    tick(1);     // E179: pop 0, push 4
    check("fp_no_overflow", 32'(overflow), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("fp_valid%0d", i), 32'(evt.event_valid), 32'h1);
      check($sformatf("fp_code%0d", i),  32'(evt.event_code),  32'(i));
      tick(1);
    end
    check("fp_drained",  32'(evt.event_valid), 32'h0);
    check("fp_overflow", 32'(overflow),        32'h0);

    // ---------------- asynchronous reset in mid-UPDATE ----------------
    do_reset();
    pressed[0] = 1'b1;
    enable     = 1'b1;
    tick(167);   // E166: key 0 just toggled, column 0 in UPDATE
    check("ar_pre_state", 32'(key_state),       32'h1);
    check("ar_pre_valid", 32'(evt.event_valid), 32'h1);
    check("ar_pre_col_n", 32'(col_n),           32'hE);
    #2;
    reset_n = 1'b0;
    #1;          // still well before the next rising edge
    check("ar_col_n",    32'(col_n),           32'hF);
    check("ar_valid",    32'(evt.event_valid), 32'h0);
    check("ar_state",    32'(key_state),       32'h0);
    check("ar_overflow", 32'(overflow),        32'h0);

    // ---------------- enable dropped during DRIVE ----------------
    do_reset();
    pressed[0] = 1'b1;
    enable     = 1'b1;
    tick(171);   // E170: column 1 in DRIVE, key 0 pressed
    check("en_pre_col_n", 32'(col_n),     32'hD);
    check("en_pre_state", 32'(key_state), 32'h1);
    enable = 1'b0;
    tick(11);    // E181: last UPDATE cycle of column 1
    check("en_col_completes", 32'(col_n), 32'hD);
    tick(1);     // E182
    check("en_idle_col_n", 32'(col_n),     32'hF);
    check("en_state_kept", 32'(key_state), 32'h1);
    tick(20);
    check("en_stays_idle",  32'(col_n),     32'hF);
    check("en_state_kept2", 32'(key_state), 32'h1);
    enable = 1'b1;
    tick(1);
    check("en_restart_col0", 32'(col_n), 32'hE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
